// File: rtl/mod_counter.sv
// mod_counter: loadable up/down modulo counter
// with cascade, terminal pulse and one-shot halt.
//
// Ports:
//   clk      rising-edge clock
//   reset    synchronous, active-high reset
//   en       count enable
//   cnt_in   cascade enable (tie high on stage 0)
//   load     synchronous load strobe
//   load_val value written on load
//   up_dn    1 = up, 0 = down
//   limit    modulus-1 (up) / reload value (down)
//   one_shot 1 = halt at terminal, 0 = wrap
//   count    registered counter value
//   tc       registered one-cycle terminal pulse
//   ripple   combinational carry to next stage
//   done     registered one-shot halted flag
module mod_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             cnt_in,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             up_dn,
  input  logic [WIDTH-1:0] limit,
  input  logic             one_shot,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ripple,
  output logic             done
);

  localparam logic [WIDTH-1:0] ONE = 1;
  localparam logic [WIDTH-1:0] ZERO = '0;

  logic step;
  logic at;
  logic at_up;
  logic at_dn;

  assign step = en & cnt_in & ~done;

  // Up uses >= so a count above limit
  // (limit lowered, or loaded high) still
  // wraps on the next step.
  assign at_up = (count >= limit);
  assign at_dn = (count == ZERO);
  assign at = up_dn ? at_up : at_dn;

  // Same-cycle carry: the next stage steps
  // on the edge this one wraps.
  assign ripple = step & at;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= ZERO;
      tc    <= 1'b0;
      done  <= 1'b0;
    end else begin
      priority case (1'b1)
        load: begin
          count <= load_val;
          tc    <= 1'b0;
          done  <= 1'b0;
        end
        (step & at & one_shot): begin
          tc   <= 1'b1;
          done <= 1'b1;
        end
        (step & at): begin
          count <= up_dn ? ZERO : limit;
          tc    <= 1'b1;
        end
        step: begin
          count <= up_dn ? count + ONE
                         : count - ONE;
          tc    <= 1'b0;
        end
        default: begin
          tc <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mod_counter.sv
// tb_mod_counter: scoreboard bench for
// mod_counter, single stage and 2-stage chain.
module tb_mod_counter;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic       cnt_in;
  logic       load;
  logic [7:0] load_val;
  logic       up_dn;
  logic [7:0] limit;
  logic       one_shot;
  logic [7:0] count;
  logic       tc;
  logic       ripple;
  logic       done;

  logic       c_reset;
  logic       c_en;
  logic [3:0] lo_cnt, hi_cnt;
  logic       lo_tc, hi_tc;
  logic       lo_rip, hi_rip;
  logic       lo_done, hi_done;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [7:0] c;
    logic       t;
    logic       d;
  } exp_t;

  exp_t       q[$];
  logic [7:0] cq[$];

  always #5 clk = ~clk;

  mod_counter #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset), .en(en),
    .cnt_in(cnt_in), .load(load),
    .load_val(load_val), .up_dn(up_dn),
    .limit(limit), .one_shot(one_shot),
    .count(count), .tc(tc),
    .ripple(ripple), .done(done)
  );

  mod_counter #(.WIDTH(4)) u_lo (
    .clk(clk), .reset(c_reset), .en(c_en),
    .cnt_in(1'b1), .load(1'b0),
    .load_val(4'd0), .up_dn(1'b1),
    .limit(4'hF), .one_shot(1'b0),
    .count(lo_cnt), .tc(lo_tc),
    .ripple(lo_rip), .done(lo_done)
  );

  mod_counter #(.WIDTH(4)) u_hi (
    .clk(clk), .reset(c_reset), .en(c_en),
    .cnt_in(lo_rip), .load(1'b0),
    .load_val(4'd0), .up_dn(1'b1),
    .limit(4'hF), .one_shot(1'b0),
    .count(hi_cnt), .tc(hi_tc),
    .ripple(hi_rip), .done(hi_done)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h",
               tag, got, exp);
    end
  endtask

  task automatic tick(
    input string      tag,
    input logic [7:0] c,
    input logic       t,
    input logic       d
  );
    exp_t e;
    q.push_back('{c: c, t: t, d: d});
    @(posedge clk);
    #1;
    e = q.pop_front();
    chk({tag, ".count"}, 32'(count), 32'(e.c));
    chk({tag, ".tc"}, 32'(tc), 32'(e.t));
    chk({tag, ".done"}, 32'(done), 32'(e.d));
  endtask

  task automatic ctick(input logic [7:0] v);
    logic [7:0] e;
    cq.push_back(v);
    @(posedge clk);
    #1;
    e = cq.pop_front();
    chk("chain", 32'({hi_cnt, lo_cnt}),
        32'(e));
  endtask

  initial begin
    int n_tc;
    int hi_n;
    int hi_at;

    reset = 1'b1;
    c_reset = 1'b1;
    c_en = 1'b0;
    en = 1'b1;
    cnt_in = 1'b1;
    load = 1'b0;
    load_val = 8'd0;
    up_dn = 1'b1;
    limit = 8'd9;
    one_shot = 1'b0;
    tick("reset", 8'd0, 1'b0, 1'b0);
    reset = 1'b0;
    c_reset = 1'b0;

    // up, modulo 10
    n_tc = 0;
    for (int i = 1; i <= 25; i++) begin
      tick("up10", 8'(i % 10),
           (i % 10) == 0, 1'b0);
      if (tc) n_tc++;
    end
    chk("up10.ntc", 32'(n_tc), 32'd2);

    // down, limit 5, from 3
    en = 1'b0;
    up_dn = 1'b0;
    limit = 8'd5;
    load = 1'b1;
    load_val = 8'd3;
    tick("dn.load", 8'd3, 1'b0, 1'b0);
    load = 1'b0;
    en = 1'b1;
    chk("dn.rip3", 32'(ripple), 32'd0);
    tick("dn", 8'd2, 1'b0, 1'b0);
    tick("dn", 8'd1, 1'b0, 1'b0);
    tick("dn", 8'd0, 1'b0, 1'b0);
    chk("dn.rip0", 32'(ripple), 32'd1);
    tick("dn.wrap", 8'd5, 1'b1, 1'b0);
    chk("dn.rip5", 32'(ripple), 32'd0);
    tick("dn", 8'd4, 1'b0, 1'b0);

    // down from above limit
    en = 1'b0;
    load = 1'b1;
    load_val = 8'd8;
    tick("dnhi.load", 8'd8, 1'b0, 1'b0);
    load = 1'b0;
    en = 1'b1;
    tick("dnhi", 8'd7, 1'b0, 1'b0);

    // one-shot up, limit 3
    en = 1'b0;
    up_dn = 1'b1;
    limit = 8'd3;
    one_shot = 1'b1;
    load = 1'b1;
    load_val = 8'd0;
    tick("os.load", 8'd0, 1'b0, 1'b0);
    load = 1'b0;
    en = 1'b1;
    tick("os", 8'd1, 1'b0, 1'b0);
    tick("os", 8'd2, 1'b0, 1'b0);
    tick("os", 8'd3, 1'b0, 1'b0);
    tick("os.halt", 8'd3, 1'b1, 1'b1);
    chk("os.rip", 32'(ripple), 32'd0);
    one_shot = 1'b0;
    for (int i = 0; i < 5; i++)
      tick("os.hold", 8'd3, 1'b0, 1'b1);
    one_shot = 1'b1;
    load = 1'b1;
    tick("os.reld", 8'd0, 1'b0, 1'b0);
    load = 1'b0;
    tick("os.run", 8'd1, 1'b0, 1'b0);

    // load above limit with en high
    one_shot = 1'b0;
    limit = 8'd50;
    load = 1'b1;
    load_val = 8'd200;
    tick("ldhi", 8'd200, 1'b0, 1'b0);
    load = 1'b0;
    tick("ldhi.wrap", 8'd0, 1'b1, 1'b0);

    // reset mid-count
    en = 1'b0;
    load = 1'b1;
    load_val = 8'd7;
    tick("rst.load", 8'd7, 1'b0, 1'b0);
    load = 1'b0;
    en = 1'b1;
    reset = 1'b1;
    tick("rst.mid", 8'd0, 1'b0, 1'b0);
    reset = 1'b0;

    // reset mid-halt
    one_shot = 1'b1;
    limit = 8'd0;
    tick("rsth.halt", 8'd0, 1'b1, 1'b1);
    reset = 1'b1;
    tick("rsth", 8'd0, 1'b0, 1'b0);
    reset = 1'b0;
    one_shot = 1'b0;

    // divide-by-1
    for (int i = 0; i < 4; i++)
      tick("lim0", 8'd0, 1'b1, 1'b0);
    en = 1'b0;
    tick("idle", 8'd0, 1'b0, 1'b0);

    // two chained 4-bit stages
    hi_n = 0;
    hi_at = 0;
    c_en = 1'b1;
    for (int i = 1; i <= 300; i++) begin
      ctick(8'(i % 256));
      if (hi_tc) begin
        hi_n++;
        hi_at = i;
      end
    end
    c_en = 1'b0;
    chk("chain.hi", 32'(hi_cnt), 32'd2);
    chk("chain.lo", 32'(lo_cnt), 32'd12);
    chk("chain.hitc_n", 32'(hi_n), 32'd1);
    chk("chain.hitc_at", 32'(hi_at), 32'd256);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/mod_counter.md
Name: mod_counter

Overview:
Parametrised, loadable up/down modulo counter. Adds over the existing 4-bit loadable counter: configurable width, runtime terminal value, direction control, count enable, cascade input/output and a one-shot (halt-at-terminal) mode. Used as the general timer/sequencer counter in the CPU datapath and peripherals. Wide counters are built by chaining stages: ripple of one stage drives cnt_in of the next.

Parameters:
WIDTH, 8, counter width in bits (>=2)

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
en  input  1  count enable
cnt_in  input  1  cascade enable; tie high for the lowest stage
load  input  1  synchronous load strobe
load_val  input  WIDTH  value written on load
up_dn  input  1  1 = count up, 0 = count down
limit  input  WIDTH  terminal value: modulus-1 (up) / reload value (down)
one_shot  input  1  1 = halt at terminal event; 0 = wrap and continue
count  output  WIDTH  registered counter value
tc  output  1  registered terminal-count pulse, one cycle
ripple  output  1  combinational cascade carry to next stage
done  output  1  registered; one-shot halted flag

Behaviour:
- Reset: synchronous, active-high; clock clk. count=0, tc=0, done=0. Inputs ignored that cycle.
- Priority per edge: reset > load > step > hold.
- load=1: count<=load_val, tc<=0, done<=0, regardless of en/cnt_in/done.
- step = en & cnt_in & ~done. Evaluated each edge; no step means count holds and tc<=0.
- Terminal condition at = up_dn ? (count >= limit) : (count == 0).
- Up, step, ~at: count<=count+1, tc<=0.
- Down, step, ~at: count<=count-1, tc<=0.
- Step & at & ~one_shot: count wraps. Up: count<=0. Down: count<=limit. tc<=1.
- Step & at & one_shot: count holds (no wrap), tc<=1, done<=1. Further steps are ignored until load or reset.
- Up mode with count > limit counts as terminal (the >= test). The next step wraps to 0 and pulses tc. This covers limit lowered mid-count and loads above limit.
- Down mode with count > limit decrements normally until 0.
- limit=0: every step is a terminal event. count stays 0 and tc pulses every step (divide-by-1).
- WIDTH-bit arithmetic only; never relies on natural overflow (up wrap is explicit via limit).
- ripple = step & at (combinational, same cycle). A chained stage increments on the same edge the lower stage wraps, so cascades have no added latency.
- tc is high for exactly one cycle per terminal event. Consecutive terminal events (limit=0) give tc high continuously.
- up_dn, limit and one_shot may change at any time; they take effect at the next edge.
- done stays high while count is held. Clearing one_shot does not clear done; only load or reset does.
- Reset mid-count or mid-halt returns to the reset state in one edge.
- Latency: count, tc and done are valid one cycle after the causing edge.

Test Plan:
- Reset then en=1, up, limit=9, one_shot=0, 25 cycles -> count 0..9,0..9,0..4; tc high only in the cycles after count 9->0 (twice).
- Down, limit=5, load 3 then step -> count 3,2,1,0,5,4; tc pulses once after 0->5; ripple high only in the cycle count==0 with step.
- One-shot up, limit=3, from 0 -> count 1,2,3, then holds at 3; tc one pulse; done=1; 5 more en cycles leave count=3. Then load 0 -> done=0 and counting resumes.
- Load + en same edge, load_val=200 > limit=50, up -> count=200, tc=0. Next step -> count=0, tc=1.
- Two WIDTH=4 stages chained (ripple->cnt_in), limit=15 both, 300 steps -> combined value = 300 mod 256 = 44 (hi=2, lo=12). Upper tc pulses once, at step 256.
- Reset asserted mid-count (count=7, en=1) -> next edge count=0, tc=0, done=0. limit=0, en=1 -> count 0 with tc high every cycle.
